// File: rtl/pio_irq_debounce.sv
// Avalon-MM PIO: synchronised, debounced input port with edge capture and a
// maskable level interrupt, plus an output register with atomic set/clear.
module pio_irq_debounce #(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in_i,
  output logic [WIDTH-1:0] pio_out_o,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd1;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_out;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_deb_next;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr_data      = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pio_in_i;
      r_s2 <= r_s1;
    end
  end

  // Each bit owns its own stability counter; a bit only follows s2 after it
  // has disagreed with the debounced value for DEBOUNCE_CYCLES edges in a row.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign w_deb_next[gi] = r_s2[gi];
      end else begin : g_deb
        localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] r_cnt;
        logic          w_diff;
        logic          w_done;

        assign w_diff = r_s2[gi] ^ r_deb[gi];
        assign w_done = w_diff && (r_cnt == CNT_LAST);

        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt <= '0;
          end else if (!w_diff || w_done) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        assign w_deb_next[gi] = w_done ? r_s2[gi] : r_deb[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      r_deb   <= w_deb_next;
      r_deb_d <= r_deb;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_event = r_deb & ~r_deb_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_event = ~r_deb & r_deb_d;
    end else begin : g_any
      assign w_event = r_deb ^ r_deb_d;
    end
  endgenerate

  assign w_w1c = (write && (address == ADDR_EDGE_CAP)) ? w_wr_data : '0;

  // A new event is OR-ed in after the clear so a colliding capture survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_event;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask <= '0;
    end else if (write && (address == ADDR_IRQ_MASK)) begin
      r_irq_mask <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= RESET_OUT;
    end else if (write) begin
      case (address)
        ADDR_DATA:    r_out <= w_wr_data;
        ADDR_OUT_SET: r_out <= r_out | w_wr_data;
        ADDR_OUT_CLR: r_out <= r_out & ~w_wr_data;
        default:      r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_edge_cap & r_irq_mask);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux = 32'(r_deb);
      ADDR_OUT_SET:  w_rd_mux = 32'(r_out);
      ADDR_OUT_CLR:  w_rd_mux = 32'(r_out);
      ADDR_IRQ_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGE_CAP: w_rd_mux = 32'(r_edge_cap);
      default:       w_rd_mux = '0;
    endcase
  end

  // Reads sample the registers before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (read) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata  = r_readdata;
  assign pio_out_o = r_out;
  assign irq       = r_irq;

endmodule

// File: tb/tb_pio_irq_debounce.sv
// Bench for pio_irq_debounce: three instances with different debounce / edge
// settings share one bus and are compared against a window-based model.
module tb_pio_irq_debounce;
  localparam int W    = 10;
  localparam int N    = 3;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [W-1:0]  pin_a, pin_b, pin_c;
  logic [31:0]   rd_a, rd_b, rd_c;
  logic [W-1:0]  pout_a, pout_b, pout_c;
  logic          irq_a, irq_b, irq_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pio_irq_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_OUT(10'h155)) dut_a (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd_a), .pio_in_i(pin_a), .pio_out_o(pout_a), .irq(irq_a));
  pio_irq_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_OUT(10'h000)) dut_b (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd_b), .pio_in_i(pin_b), .pio_out_o(pout_b), .irq(irq_b));
  pio_irq_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(2), .RESET_OUT(10'h000)) dut_c (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(rd_c), .pio_in_i(pin_c), .pio_out_o(pout_c), .irq(irq_c));

  // Reference model: a debounced bit flips once the last DEBOUNCE_CYCLES pin
  // samples (seen two edges late through the synchroniser) all disagree with it.
  int           dcp [N] = '{4, 0, 3};
  int           etp [N] = '{0, 0, 2};
  logic [W-1:0] rop [N] = '{10'h155, 10'h000, 10'h000};
  logic [W-1:0] hist [N][MAXC];
  logic [W-1:0] m_deb [N], m_debd [N], m_cap [N], m_mask [N], m_out [N];
  logic [31:0]  m_rd [N];
  logic         m_irq [N];
  int           cyc = 0;

  task automatic model_step();
    logic [W-1:0] p [N];
    logic [W-1:0] nd, ev, wd, w1c;
    logic [31:0]  rv;
    logic         stable;
    int           t;
    p[0] = pin_a; p[1] = pin_b; p[2] = pin_c;
    t = cyc;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget: used %0d cycles, limit %0d", t, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    wd = writedata[W-1:0];
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        hist[i][t] = '0;
        if (t > 0) hist[i][t-1] = '0;
        m_deb[i] = '0; m_debd[i] = '0; m_cap[i] = '0; m_mask[i] = '0;
        m_out[i] = rop[i]; m_rd[i] = '0; m_irq[i] = 1'b0;
      end else begin
        hist[i][t] = p[i];
        nd = m_deb[i];
        for (int b = 0; b < W; b++) begin
          if (dcp[i] <= 1) begin
            nd[b] = (t >= 2) ? hist[i][t-2][b] : 1'b0;
          end else begin
            stable = 1'b1;
            for (int j = t - dcp[i] - 1; j <= t - 2; j++)
              if (j < 0 || hist[i][j][b] == m_deb[i][b]) stable = 1'b0;
            if (stable) nd[b] = ~m_deb[i][b];
          end
        end
        case (etp[i])
          0:       ev = m_deb[i] & ~m_debd[i];
          1:       ev = ~m_deb[i] & m_debd[i];
          default: ev = m_deb[i] ^ m_debd[i];
        endcase
        case (address)
          3'd0:    rv = 32'(m_deb[i]);
          3'd1:    rv = 32'(m_out[i]);
          3'd2:    rv = 32'(m_out[i]);
          3'd3:    rv = 32'(m_mask[i]);
          3'd4:    rv = 32'(m_cap[i]);
          default: rv = 32'd0;
        endcase
        if (read) m_rd[i] = rv;
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        w1c = (write && address == 3'd4) ? wd : '0;
        m_cap[i] = (m_cap[i] & ~w1c) | ev;
        if (write) begin
          case (address)
            3'd0:    m_out[i] = wd;
            3'd1:    m_out[i] = m_out[i] | wd;
            3'd2:    m_out[i] = m_out[i] & ~wd;
            3'd3:    m_mask[i] = wd;
            default: ;
          endcase
        end
        m_debd[i] = m_deb[i];
        m_deb[i]  = nd;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    $display("read  addr=%0d a=%h b=%h c=%h", a, rd_a, rd_b, rd_c);
  endtask

  task automatic test_reset();
    int addrs [3] = '{0, 3, 4};
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (pout_a !== 10'h155) begin errors++; $display("FAIL reset_out_a: got %h want %h", pout_a, 10'h155); end
    checks++; if (pout_b !== 10'h000) begin errors++; $display("FAIL reset_out_b: got %h want %h", pout_b, 10'h000); end
    checks++; if ({irq_a, irq_b, irq_c} !== 3'b000) begin errors++; $display("FAIL reset_irq: got %b want 000", {irq_a, irq_b, irq_c}); end
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", rd_a); end
    for (int k = 0; k < 3; k++) begin
      bus_read(3'(addrs[k]));
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_read_%0d: got %h want 0", addrs[k], rd_a); end
    end
  endtask

  task automatic test_output_atomics();
    logic [2:0]   wa [3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0]  wd [3] = '{32'h0F0, 32'h003, 32'h030};
    logic [W-1:0] ex [3] = '{10'h0F0, 10'h0F3, 10'h0C3};
    for (int k = 0; k < 3; k++) begin
      bus_write(wa[k], wd[k]);
      checks++; if (pout_a !== ex[k]) begin errors++; $display("FAIL out_atomic_a_%0d: got %h want %h", k, pout_a, ex[k]); end
      checks++; if (pout_c !== ex[k]) begin errors++; $display("FAIL out_atomic_c_%0d: got %h want %h", k, pout_c, ex[k]); end
    end
    bus_read(3'd1);
    checks++; if (rd_a !== 32'h0C3) begin errors++; $display("FAIL out_readback: got %h want %h", rd_a, 32'h0C3); end
  endtask

  task automatic test_debounce();
    bus_write(3'd4, 32'h3FF);
    pin_a = 10'h004;
    tick(); tick(); tick();
    pin_a = 10'h000;
    address = 3'd0; read = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL glitch_data_%0d: got %h want 0", n, rd_a); end
    end
    read = 1'b0;
    bus_read(3'd4);
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL glitch_edge_cap: got %h want 0", rd_a); end
    address = 3'd0; read = 1'b1;
    pin_a = 10'h004;
    for (int n = 1; n <= 7; n++) begin
      tick();
      checks++; if (rd_a !== m_rd[0]) begin errors++; $display("FAIL deb_model_%0d: got %h want %h", n, rd_a, m_rd[0]); end
      if (n == 6) begin
        checks++; if (rd_a[2] !== 1'b0) begin errors++; $display("FAIL deb_early: got %b want 0", rd_a[2]); end
      end
      if (n == 7) begin
        checks++; if (rd_a[2] !== 1'b1) begin errors++; $display("FAIL deb_settled: got %b want 1", rd_a[2]); end
      end
    end
    address = 3'd4;
    tick();
    read = 1'b0;
    checks++; if (rd_a !== 32'h004) begin errors++; $display("FAIL deb_edge_cap: got %h want %h", rd_a, 32'h004); end
  endtask

  task automatic test_irq();
    bus_write(3'd4, 32'h3FF);
    bus_write(3'd3, 32'h004);
    pin_b = 10'h004;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++; if (irq_b !== (n >= 5)) begin errors++; $display("FAIL irq_rise_%0d: got %b want %b", n, irq_b, (n >= 5)); end
    end
    address = 3'd4; writedata = 32'h004; write = 1'b1;
    tick();
    write = 1'b0;
    checks++; if (irq_b !== 1'b1) begin errors++; $display("FAIL irq_hold_after_w1c: got %b want 1", irq_b); end
    tick();
    checks++; if (irq_b !== m_irq[1]) begin errors++; $display("FAIL irq_w1c_model: got %b want %b", irq_b, m_irq[1]); end
    tick();
    checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq_b); end
    bus_write(3'd3, 32'h000);
    pin_b = 10'h00C;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++; if (irq_b !== 1'b0) begin errors++; $display("FAIL irq_masked_%0d: got %b want 0", n, irq_b); end
    end
    bus_read(3'd4);
    checks++; if (rd_b !== 32'h008) begin errors++; $display("FAIL masked_edge_cap: got %h want %h", rd_b, 32'h008); end
  endtask

  task automatic test_w1c_collision();
    bus_write(3'd4, 32'h3FF);
    pin_b = 10'h00D;
    tick(); tick(); tick();
    address = 3'd4; writedata = 32'h001; write = 1'b1;
    tick();
    write = 1'b0;
    bus_read(3'd4);
    checks++; if (rd_b !== 32'h001) begin errors++; $display("FAIL w1c_collision: got %h want %h", rd_b, 32'h001); end
  endtask

  task automatic test_edge_any_reset();
    bus_write(3'd4, 32'h3FF);
    pin_c = 10'h002;
    for (int n = 0; n < 8; n++) tick();
    bus_read(3'd4);
    checks++; if (rd_c !== 32'h002) begin errors++; $display("FAIL any_edge_rise: got %h want %h", rd_c, 32'h002); end
    bus_write(3'd4, 32'h002);
    pin_c = 10'h000;
    for (int n = 0; n < 8; n++) tick();
    bus_read(3'd4);
    checks++; if (rd_c !== 32'h002) begin errors++; $display("FAIL any_edge_fall: got %h want %h", rd_c, 32'h002); end
    bus_write(3'd4, 32'h3FF);
    pin_c = 10'h002;
    for (int n = 0; n < 4; n++) tick();
    pin_c = 10'h000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (pout_a !== 10'h155) begin errors++; $display("FAIL midreset_out: got %h want %h", pout_a, 10'h155); end
    for (int n = 0; n < 10; n++) tick();
    bus_read(3'd4);
    checks++; if (rd_c !== 32'h0) begin errors++; $display("FAIL midreset_edge_cap: got %h want 0", rd_c); end
    bus_read(3'd0);
    checks++; if (rd_c !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", rd_c); end
  endtask

  task automatic test_random();
    logic [31:0]  drd [N];
    logic [W-1:0] dout [N];
    logic         dirq [N];
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 7) == 0) pin_a[b] = ~pin_a[b];
        if ($urandom_range(0, 7) == 0) pin_b[b] = ~pin_b[b];
        if ($urandom_range(0, 5) == 0) pin_c[b] = ~pin_c[b];
      end
      address   = 3'($urandom_range(0, 7));
      read      = 1'($urandom_range(0, 1));
      write     = ($urandom_range(0, 3) == 0);
      writedata = $urandom;
      reset     = ($urandom_range(0, 199) == 0);
      tick();
      $display("rand %0d rst=%0b rd=%0b wr=%0b addr=%0d wd=%h", n, reset, read, write, address, writedata);
      drd[0] = rd_a;   drd[1] = rd_b;   drd[2] = rd_c;
      dout[0] = pout_a; dout[1] = pout_b; dout[2] = pout_c;
      dirq[0] = irq_a; dirq[1] = irq_b; dirq[2] = irq_c;
      for (int i = 0; i < N; i++) begin
        checks++; if (drd[i] !== m_rd[i]) begin errors++; $display("FAIL rand_readdata_%0d cyc %0d: got %h want %h", i, n, drd[i], m_rd[i]); end
        checks++; if (dout[i] !== m_out[i]) begin errors++; $display("FAIL rand_out_%0d cyc %0d: got %h want %h", i, n, dout[i], m_out[i]); end
        checks++; if (dirq[i] !== m_irq[i]) begin errors++; $display("FAIL rand_irq_%0d cyc %0d: got %b want %b", i, n, dirq[i], m_irq[i]); end
      end
    end
    reset = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
    pin_a = '0; pin_b = '0; pin_c = '0;
    test_reset();
    test_output_atomics();
    test_debounce();
    test_irq();
    test_w1c_collision();
    test_edge_any_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_irq_debounce.md
Name: pio_irq_debounce

Overview:
Parametrised successor to the simple Nios-II input/output PIO pair: one Avalon-MM slave combining an input port and an output port.
- Input path: 2-FF synchroniser, per-bit debounce, edge capture, maskable level interrupt.
- Output path: data register plus atomic set/clear registers.
- Sits inside the Qsys/Platform Designer cpu_system. Inputs are driven by board pins (sw, key); outputs drive ledr or gpio.

Parameters:
WIDTH, 10, number of input bits and output bits (1..32).
DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the debounced value changes; 0 bypasses debounce.
EDGE_TYPE, 0, edge that sets an edge_cap bit: 0 = rising, 1 = falling, 2 = any.
RESET_OUT, 0, reset value of the output register (WIDTH bits).

Ports:
clk  in  1  system clock; only clock.
reset  in  1  synchronous, active-high reset.
address  in  3  Avalon word address.
read  in  1  Avalon read strobe.
write  in  1  Avalon write strobe.
writedata  in  32  Avalon write data.
readdata  out  32  Avalon read data, registered.
pio_in_i  in  WIDTH  asynchronous input pins.
pio_out_o  out  WIDTH  output register.
irq  out  1  level interrupt, registered.

Behaviour:
Reset: applied on a clk edge with reset=1.
- pio_out_o=RESET_OUT.
- readdata=0, irq=0.
- sync stages, debounced value, debounce counters, edge_cap and irq_mask all 0.
- Reset overrides any concurrent read or write.

Register map. Bits above WIDTH read 0 and are ignored on write.
- 0 DATA: read = debounced input; write = load out register.
- 1 OUT_SET: read = out register; write = out |= writedata.
- 2 OUT_CLR: read = out register; write = out &= ~writedata.
- 3 IRQ_MASK: read/write.
- 4 EDGE_CAP: read; write-1-to-clear.
- 5..7: read 0; writes ignored.

Avalon:
- No waitrequest; fixed read latency 1. readdata is loaded on the edge where read=1 and is valid the following cycle.
- readdata holds its value when read=0.
- read and write in the same cycle: readdata returns the pre-write value.
- Register writes take effect on the edge where write=1.

Input path, per bit:
- Synchroniser: s1<=pin, s2<=s1.
- DEBOUNCE_CYCLES=0: deb<=s2.
- DEBOUNCE_CYCLES>0:
  - s2==deb: counter cleared to 0.
  - s2!=deb and counter<DEBOUNCE_CYCLES-1: counter increments.
  - s2!=deb and counter==DEBOUNCE_CYCLES-1: deb<=s2 and counter cleared.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Glitches shorter than DEBOUNCE_CYCLES cycles at s2 never reach deb.

Edge capture:
- deb_d<=deb.
- Edge event per EDGE_TYPE: rising = deb & ~deb_d; falling = ~deb & deb_d; any = deb ^ deb_d.
- An event sets edge_cap on the next edge. Bits are sticky until written 1 at address 4.
- Event and W1C on the same bit in the same cycle: bit stays 1 (capture wins).
- After reset, deb=0. A pin held high therefore produces a rising edge once it propagates; firmware clears edge_cap after enabling.

Latency: pin change sampled into s1 at edge k.
- s2 at k+1.
- deb at k+1+DEBOUNCE_CYCLES (k+2 when DEBOUNCE_CYCLES=0).
- edge_cap at deb_edge+1.
- irq at edge_cap_edge+1, where irq<=|(edge_cap & irq_mask).
- Clearing edge_cap or the mask deasserts irq one cycle after the register update.

Test Plan:
- Reset: drive reset=1 for 2 cycles with RESET_OUT=10'h155 -> pio_out_o=0x155, irq=0, reading addresses 0/3/4 gives readdata 0x000.
- Output atomics: write DATA=0x0F0, then OUT_SET=0x003, then OUT_CLR=0x030 -> pio_out_o goes 0x0F0 -> 0x0F3 -> 0x0C3; read address 1 returns 0x0C3 one cycle after read.
- Debounce with DEBOUNCE_CYCLES=4, EDGE_TYPE=0:
  - Bit 2 high for 3 cycles then low -> DATA stays 0, edge_cap 0.
  - Bit 2 held high -> DATA bit2=1 at k+5, edge_cap=0x004 at k+6.
- Interrupt, bypass debounce (DEBOUNCE_CYCLES=0):
  - Mask=0x004, rising on bit 2 at k -> irq=1 at k+4.
  - Write 0x004 to address 4 -> irq=0 two cycles after the write edge.
  - Mask=0 with edge_cap set -> irq stays 0.
- W1C collision: a rising edge event on bit 0 in the same cycle as a write of 0x001 to EDGE_CAP -> edge_cap bit0 stays 1.
- EDGE_TYPE=2 and mid-operation reset:
  - Toggle bit 1 high then low -> edge_cap bit1 set by each transition.
  - Assert reset while a debounce counter is at 2 -> deb, counter and edge_cap return to 0; no edge is reported from the pre-reset toggle.
